alu_seq_ctrl: RTL and testbench

Parametrised ALU sequencing controller with an integrated accumulator datapath. It accepts one operation per `load` handshake and executes single-cycle logic/arithmetic ops or a multi-cycle shift-add multiply. It detects overflow, holds an error state in one of two modes (timed or sticky), and keeps a saturating overflow count. It sits between the operand/command source and the result consumer, and replaces the fixed 2-bit off/ready/run/run_error controller.

---
 rtl/alu_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller with accumulator datapath: single-cycle logic/arith ops,
// WIDTH-cycle shift-add multiply, overflow error handling and a saturating overflow count.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ERR_HOLD = 2,
  parameter int unsigned STICKY   = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             load,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             err_clr,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned IterW = $clog2(WIDTH);
  localparam int unsigned HoldW = $clog2(ERR_HOLD + 1);

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpXor  = 3'b101;
  localparam logic [2:0] OpShl  = 3'b110;
  localparam logic [2:0] OpMul  = 3'b111;

  typedef enum logic [1:0] {StOff, StReady, StRun, StError} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [IterW-1:0]   iter_q;
  logic [HoldW-1:0]   hold_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               run_last;
  logic [WIDTH-1:0]   res_val;
  logic               res_ovf;

  // Bit WIDTH of alu_res is the overflow flag (carry, borrow or shifted-out MSB).
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OpPass: alu_res = {1'b0, opnd_q};
      OpAdd:  alu_res = {1'b0, acc_q} + {1'b0, opnd_q};
      OpSub:  alu_res = {1'b0, acc_q} - {1'b0, opnd_q};
      OpAnd:  alu_res = {1'b0, acc_q & opnd_q};
      OpOr:   alu_res = {1'b0, acc_q | opnd_q};
      OpXor:  alu_res = {1'b0, acc_q ^ opnd_q};
      OpShl:  alu_res = {acc_q, 1'b0};
      OpMul:  alu_res = '0;
    endcase
  end

  // Multiplier sits in the low half of prod_q; each step adds A to the high half and shifts right.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
    prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
    run_last = (op_q != OpMul) || (iter_q == IterW'(WIDTH - 1));
    res_val  = (op_q == OpMul) ? prod_nxt[WIDTH-1:0] : alu_res[WIDTH-1:0];
    res_ovf  = (op_q == OpMul) ? |prod_nxt[2*WIDTH-1:WIDTH] : alu_res[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReady;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OpPass;
      prod_q  <= '0;
      iter_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!on) begin
        state_q <= StOff;
      end else begin
        unique case (state_q)
          StOff: state_q <= StReady;
          StReady: begin
            if (load) begin
              op_q    <= op;
              opnd_q  <= operand;
              prod_q  <= {{WIDTH{1'b0}}, operand};
              iter_q  <= '0;
              state_q <= StRun;
            end
          end
          StRun: begin
            if (op_q == OpMul) begin
              prod_q <= prod_nxt;
              iter_q <= iter_q + IterW'(1);
            end
            if (run_last) begin
              acc_q   <= res_val;
              done_q  <= 1'b1;
              hold_q  <= '0;
              state_q <= res_ovf ? StError : StReady;
              if (res_ovf && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StError: begin
            if (STICKY != 0) begin
              if (err_clr) state_q <= StReady;
            end else if (hold_q == HoldW'(ERR_HOLD - 1)) begin
              state_q <= StReady;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
        endcase
      end
    end
  end

  assign ready     = (state_q == StReady);
  assign busy      = (state_q == StRun);
  assign error     = (state_q == StError);
  assign done      = done_q;
  assign result    = acc_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a timed-error instance and a sticky-error instance
// share clock, reset, enable, opcode and operand; each has its own load strobe.
module tb_alu_seq_ctrl;

  localparam logic [2:0] PASS = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1, on = 1'b1, load = 1'b0, load_s = 1'b0, err_clr = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] operand = 8'h00;

  logic       ready, busy, done, error;
  logic [7:0] result;
  logic [3:0] ovf_count;
  logic       ready_s, busy_s, done_s, error_s;
  logic [7:0] result_s;
  logic [3:0] ovf_count_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(8), .ERR_HOLD(2), .STICKY(0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .on(on), .load(load), .op(op), .operand(operand),
    .err_clr(err_clr), .ready(ready), .busy(busy), .done(done), .error(error),
    .result(result), .ovf_count(ovf_count)
  );

  alu_seq_ctrl #(.WIDTH(8), .ERR_HOLD(2), .STICKY(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .on(on), .load(load_s), .op(op), .operand(operand),
    .err_clr(err_clr), .ready(ready_s), .busy(busy_s), .done(done_s), .error(error_s),
    .result(result_s), .ovf_count(ovf_count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge on the selected instance.
  task automatic start(input logic [2:0] o, input logic [7:0] b, input bit sticky);
    op = o;
    operand = b;
    if (sticky) load_s = 1'b1;
    else load = 1'b1;
    tick();
    load = 1'b0;
    load_s = 1'b0;
  endtask

  task automatic op_run(input logic [2:0] o, input logic [7:0] b, input bit sticky);
    start(o, b, sticky);
    tick();
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 16; i++) begin
      if (ready) break;
      tick();
    end
    ok = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({ready, busy, done, error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1000", {ready, busy, done, error});
    end
    n_chk++;
    if (result !== 8'h00 || ovf_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values: got result=%h cnt=%0d want 00/0", result, ovf_count);
    end
  endtask

  task automatic test_pass_add();
    start(PASS, 8'h7F, 1'b0);
    n_chk++;
    if ({busy, done, ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL pass_busy: got busy,done,ready=%b want 100", {busy, done, ready});
    end
    tick();
    n_chk++;
    if ({busy, done, ready} !== 3'b011 || result !== 8'h7F) begin
      n_fail++;
      $display("FAIL pass_done: got flags=%b result=%h want 011/7f", {busy, done, ready}, result);
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b want 0", done);
    end
    op_run(ADD, 8'h01, 1'b0);
    n_chk++;
    if (result !== 8'h80 || done !== 1'b1 || error !== 1'b0 || ovf_count !== 4'd0) begin
      n_fail++;
      $display("FAIL add_basic: got result=%h done=%b err=%b cnt=%0d want 80/1/0/0",
               result, done, error, ovf_count);
    end
  endtask

  task automatic test_ovf_timed();
    op_run(PASS, 8'hF0, 1'b0);
    op_run(ADD, 8'h20, 1'b0);
    n_chk++;
    if (result !== 8'h10 || done !== 1'b1 || error !== 1'b1 || ovf_count !== 4'd1) begin
      n_fail++;
      $display("FAIL add_ovf: got result=%h done=%b err=%b cnt=%0d want 10/1/1/1",
               result, done, error, ovf_count);
    end
    // err_clr and load must both be ignored while in timed ERROR.
    err_clr = 1'b1;
    load = 1'b1;
    op = PASS;
    operand = 8'h55;
    tick();
    n_chk++;
    if (error !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_hold1: got err=%b done=%b want 1/0", error, done);
    end
    tick();
    err_clr = 1'b0;
    load = 1'b0;
    n_chk++;
    if (error !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || result !== 8'h10) begin
      n_fail++;
      $display("FAIL err_exit: got err=%b rdy=%b busy=%b result=%h want 0/1/0/10",
               error, ready, busy, result);
    end
  endtask

  task automatic test_logic();
    bit ok;
    op_run(PASS, 8'hCA, 1'b0);
    op_run(AND_, 8'h0F, 1'b0);
    n_chk++;
    if (result !== 8'h0A) begin
      n_fail++;
      $display("FAIL and: got %h want 0a", result);
    end
    op_run(OR_, 8'hF0, 1'b0);
    n_chk++;
    if (result !== 8'hFA) begin
      n_fail++;
      $display("FAIL or: got %h want fa", result);
    end
    op_run(XOR_, 8'hFF, 1'b0);
    n_chk++;
    if (result !== 8'h05) begin
      n_fail++;
      $display("FAIL xor: got %h want 05", result);
    end
    op_run(SHL, 8'h00, 1'b0);
    n_chk++;
    if (result !== 8'h0A || error !== 1'b0) begin
      n_fail++;
      $display("FAIL shl: got %h err=%b want 0a/0", result, error);
    end
    op_run(SUB, 8'h01, 1'b0);
    n_chk++;
    if (result !== 8'h09 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL sub: got %h err=%b want 09/0", result, error);
    end
    op_run(PASS, 8'h81, 1'b0);
    op_run(SHL, 8'h00, 1'b0);
    n_chk++;
    if (result !== 8'h02 || error !== 1'b1 || ovf_count !== 4'd2) begin
      n_fail++;
      $display("FAIL shl_ovf: got %h err=%b cnt=%0d want 02/1/2", result, error, ovf_count);
    end
    wait_ready(ok);
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    op_run(PASS, 8'h10, 1'b0);
    load = 1'b1;
    op = ADD;
    operand = 8'h01;
    repeat (4) begin
      tick();
      if (done) dn++;
    end
    load = 1'b0;
    n_chk++;
    if (result !== 8'h12 || dn != 2) begin
      n_fail++;
      $display("FAIL back_to_back: got result=%h dones=%0d want 12/2", result, dn);
    end
  endtask

  task automatic test_mul();
    bit ok;
    int cyc;
    op_run(PASS, 8'h0C, 1'b0);
    start(MUL, 8'h0A, 1'b0);
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) cyc++;
      else break;
    end
    n_chk++;
    if (cyc != 8 || done !== 1'b1 || result !== 8'h78 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_basic: got cyc=%0d done=%b result=%h err=%b want 8/1/78/0",
               cyc, done, result, error);
    end
    op_run(PASS, 8'h0C, 1'b0);
    start(MUL, 8'h20, 1'b0);
    repeat (8) tick();
    n_chk++;
    if (result !== 8'h80 || done !== 1'b1 || error !== 1'b1 || ovf_count !== 4'd3) begin
      n_fail++;
      $display("FAIL mul_ovf: got result=%h done=%b err=%b cnt=%0d want 80/1/1/3",
               result, done, error, ovf_count);
    end
    wait_ready(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mul_ovf_exit: got ready=%b want 1", ready);
    end
  endtask

  task automatic test_abort();
    start(MUL, 8'h03, 1'b0);
    repeat (3) tick();
    on = 1'b0;
    tick();
    n_chk++;
    if ({ready, busy, error, done} !== 4'b0000 || result !== 8'h80) begin
      n_fail++;
      $display("FAIL abort_off: got flags=%b result=%h want 0000/80",
               {ready, busy, error, done}, result);
    end
    tick();
    on = 1'b1;
    n_chk++;
    if (done !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: got done=%b ready=%b want 0/0", done, ready);
    end
    tick();
    n_chk++;
    if (ready !== 1'b1 || result !== 8'h80 || ovf_count !== 4'd3) begin
      n_fail++;
      $display("FAIL abort_resume: got rdy=%b result=%h cnt=%0d want 1/80/3",
               ready, result, ovf_count);
    end
    op_run(PASS, 8'h05, 1'b0);
    start(MUL, 8'h03, 1'b0);
    repeat (8) tick();
    n_chk++;
    if (result !== 8'h0F || done !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_after_abort: got result=%h done=%b err=%b want 0f/1/0",
               result, done, error);
    end
  endtask

  task automatic test_sticky();
    op_run(PASS, 8'h03, 1'b1);
    op_run(SUB, 8'h05, 1'b1);
    n_chk++;
    if (result_s !== 8'hFE || error_s !== 1'b1 || done_s !== 1'b1 || ovf_count_s !== 4'd1) begin
      n_fail++;
      $display("FAIL sticky_sub: got result=%h err=%b done=%b cnt=%0d want fe/1/1/1",
               result_s, error_s, done_s, ovf_count_s);
    end
    load_s = 1'b1;
    op = PASS;
    operand = 8'h11;
    repeat (5) tick();
    load_s = 1'b0;
    n_chk++;
    if (error_s !== 1'b1 || result_s !== 8'hFE || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_hold: got err=%b result=%h busy=%b want 1/fe/0",
               error_s, result_s, busy_s);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (ready_s !== 1'b1 || error_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr: got rdy=%b err=%b want 1/0", ready_s, error_s);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    bit all_ok = 1'b1;
    op_run(PASS, 8'hFF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op_run(ADD, 8'hFF, 1'b0);
      wait_ready(ok);
      all_ok &= ok;
    end
    n_chk++;
    if (ovf_count !== 4'd15 || !all_ok) begin
      n_fail++;
      $display("FAIL saturate: got cnt=%0d ok=%b want 15/1", ovf_count, all_ok);
    end
    start(MUL, 8'h05, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (ovf_count !== 4'd0 || result !== 8'h00 || {ready, busy, done, error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_run: got cnt=%0d result=%h flags=%b want 0/00/1000",
               ovf_count, result, {ready, busy, done, error});
    end
  endtask

  initial begin
    test_reset();
    test_pass_add();
    test_ovf_timed();
    test_logic();
    test_back_to_back();
    test_mul();
    test_abort();
    test_sticky();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
